// File: rtl/alu_pkg.sv
// Shared op/state encodings and decode helpers for the multi-cycle ALU.
// Optional iterative mul/div is enabled by defining ALU_MC_MULDIV_EN.
package alu_pkg;

    localparam int unsigned OP_W = 5;

    typedef enum logic [OP_W-1:0] {
        OP_PASS  = 5'h00,
        OP_ADD   = 5'h01,
        OP_SUB   = 5'h02,
        OP_AND   = 5'h03,
        OP_OR    = 5'h04,
        OP_XOR   = 5'h05,
        OP_SLL   = 5'h06,
        OP_SRL   = 5'h07,
        OP_SRA   = 5'h08,
        OP_EQ    = 5'h09,
        OP_NE    = 5'h0A,
        OP_LTU   = 5'h0B,
        OP_GTU   = 5'h0C,
        OP_GEU   = 5'h0D,
        OP_LT    = 5'h0E,
        OP_GT    = 5'h0F,
        OP_GE    = 5'h10,
        OP_LUI   = 5'h11,
        OP_MUL   = 5'h12,
        OP_MULHU = 5'h13,
        OP_DIVU  = 5'h14,
        OP_REMU  = 5'h15,
        OP_DIV   = 5'h16,
        OP_REM   = 5'h17,
        OP_RSV18 = 5'h18,
        OP_RSV19 = 5'h19,
        OP_RSV1A = 5'h1A,
        OP_RSV1B = 5'h1B,
        OP_RSV1C = 5'h1C,
        OP_RSV1D = 5'h1D,
        OP_RSV1E = 5'h1E,
        OP_RSV1F = 5'h1F
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } alu_state_e;

    function automatic logic is_cmp(input alu_op_e op);
        return (op >= OP_EQ) && (op <= OP_GE);
    endfunction

    function automatic logic is_muldiv(input alu_op_e op);
        return (op >= OP_MUL) && (op <= OP_REM);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative engine: one shift-add (mul) or restoring-subtract (div) step per cycle.
// Only compiled when ALU_MC_MULDIV_EN is defined; divide works on operand magnitudes.
`ifdef ALU_MC_MULDIV_EN
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            div_i,
    input  logic            sgn_i,
    input  logic [XLEN-1:0] srca_i,
    input  logic [XLEN-1:0] srcb_i,
    output logic            last_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    localparam int unsigned CW = $clog2(XLEN + 1);

    logic [CW-1:0]   cnt_q, cnt_d;
    logic            div_q, div_d;
    logic            last_q, last_d;
    logic [XLEN-1:0] opnd_q, opnd_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN:0]   sum_c;
    logic [XLEN:0]   shl_c;
    logic            ge_c;

    // mul: {hi,lo} shifts right, lo holds multiplier; div: {hi,lo} shifts left, lo collects quotient
    always_comb begin
        cnt_d  = cnt_q;
        div_d  = div_q;
        opnd_d = opnd_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        sum_c  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        shl_c  = {hi_q, lo_q[XLEN-1]};
        ge_c   = (shl_c >= {1'b0, opnd_q});
        if (start_i) begin
            cnt_d = CW'(XLEN);
            div_d = div_i;
            hi_d  = '0;
            if (div_i) begin
                opnd_d = (sgn_i && srca_i[XLEN-1]) ? -srca_i : srca_i;
                lo_d   = (sgn_i && srcb_i[XLEN-1]) ? -srcb_i : srcb_i;
            end else begin
                opnd_d = srcb_i;
                lo_d   = srca_i;
            end
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
            if (div_q) begin
                hi_d = ge_c ? XLEN'(shl_c - {1'b0, opnd_q}) : shl_c[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], ge_c};
            end else begin
                hi_d = sum_c[XLEN:1];
                lo_d = {sum_c[0], lo_q[XLEN-1:1]};
            end
        end
        last_d = (cnt_d == CW'(1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            div_q  <= 1'b0;
            last_q <= 1'b0;
            opnd_q <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            last_q <= last_d;
            opnd_q <= opnd_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    assign last_o = last_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule
`endif

// File: rtl/alu_mc.sv
// Multi-cycle ALU with registered, handshaked output; res = srcb OP srca.
// Define ALU_MC_MULDIV_EN to enable iterative MUL/MULHU/DIVU/REMU/DIV/REM.
module alu_mc
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_op,
    input  logic [XLEN-1:0] in_srca,
    input  logic [XLEN-1:0] in_srcb,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_res,
    output logic            out_flag,
    output logic            out_illegal,
    output logic            busy
);

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_res_q, out_res_d;
    logic            out_flag_q, out_flag_d;
    logic            out_illegal_q, out_illegal_d;

    alu_op_e         op_c;
    logic [SHW-1:0]  shamt_c;
    logic            idle_c;
    logic            accept_c;
    logic            md_accept_c;
    logic            md_load_c;
    logic [XLEN-1:0] md_res_c;
    logic [XLEN-1:0] sc_res_c;
    logic            sc_flag_c;
    logic            sc_illegal_c;

    assign op_c     = alu_op_e'(in_op);
    assign shamt_c  = in_srca[SHW-1:0];
    assign in_ready = idle_c && (!out_valid_q || out_ready);
    assign accept_c = in_valid && in_ready;

    // Single-cycle ops; everything not listed (incl. mul/div when disabled) is illegal
    always_comb begin
        sc_res_c     = '0;
        sc_flag_c    = 1'b0;
        sc_illegal_c = 1'b0;
        case (op_c)
            OP_PASS: sc_res_c = in_srcb;
            OP_ADD:  sc_res_c = in_srcb + in_srca;
            OP_SUB:  sc_res_c = in_srcb - in_srca;
            OP_AND:  sc_res_c = in_srcb & in_srca;
            OP_OR:   sc_res_c = in_srcb | in_srca;
            OP_XOR:  sc_res_c = in_srcb ^ in_srca;
            OP_SLL:  sc_res_c = in_srcb << shamt_c;
            OP_SRL:  sc_res_c = in_srcb >> shamt_c;
            OP_SRA:  sc_res_c = $signed(in_srcb) >>> shamt_c;
            OP_EQ:   sc_flag_c = (in_srcb == in_srca);
            OP_NE:   sc_flag_c = (in_srcb != in_srca);
            OP_LTU:  sc_flag_c = (in_srcb < in_srca);
            OP_GTU:  sc_flag_c = (in_srcb > in_srca);
            OP_GEU:  sc_flag_c = (in_srcb >= in_srca);
            OP_LT:   sc_flag_c = ($signed(in_srcb) < $signed(in_srca));
            OP_GT:   sc_flag_c = ($signed(in_srcb) > $signed(in_srca));
            OP_GE:   sc_flag_c = ($signed(in_srcb) >= $signed(in_srca));
            OP_LUI:  sc_res_c = in_srcb << 16;
            default: sc_illegal_c = 1'b1;
        endcase
        if (is_cmp(op_c)) begin
            sc_res_c = XLEN'(sc_flag_c);
        end
    end

`ifdef ALU_MC_MULDIV_EN
    alu_state_e      state_q, state_d;
    alu_op_e         op_q, op_d;
    logic            a_zero_q, a_zero_d;
    logic            a_neg_q, a_neg_d;
    logic            b_neg_q, b_neg_d;
    logic            md_last;
    logic [XLEN-1:0] md_hi;
    logic [XLEN-1:0] md_lo;

    assign idle_c      = (state_q == IDLE);
    assign busy        = !idle_c;
    assign md_accept_c = accept_c && is_muldiv(op_c);
    assign md_load_c   = (state_q == FIN);

    alu_muldiv_iter #(
        .XLEN (XLEN)
    ) u_iter (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (md_accept_c),
        .div_i   (op_c >= OP_DIVU),
        .sgn_i   ((op_c == OP_DIV) || (op_c == OP_REM)),
        .srca_i  (in_srca),
        .srcb_i  (in_srcb),
        .last_o  (md_last),
        .hi_o    (md_hi),
        .lo_o    (md_lo)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_zero_d = a_zero_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        case (state_q)
            IDLE: begin
                if (md_accept_c) begin
                    state_d  = CALC;
                    op_d     = op_c;
                    a_zero_d = (in_srca == '0);
                    a_neg_d  = in_srca[XLEN-1];
                    b_neg_d  = in_srcb[XLEN-1];
                end
            end
            CALC:    if (md_last) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sign fix-up on the magnitude result; a zero divisor forces an all-ones quotient
    always_comb begin
        md_res_c = md_lo;
        case (op_q)
            OP_MULHU, OP_REMU: md_res_c = md_hi;
            OP_DIV: begin
                if (a_zero_q) begin
                    md_res_c = '1;
                end else if (a_neg_q ^ b_neg_q) begin
                    md_res_c = -md_lo;
                end
            end
            OP_REM:  md_res_c = b_neg_q ? -md_hi : md_hi;
            default: md_res_c = md_lo;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= OP_PASS;
            a_zero_q <= 1'b0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_zero_q <= a_zero_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
        end
    end
`else
    assign idle_c      = 1'b1;
    assign busy        = 1'b0;
    assign md_accept_c = 1'b0;
    assign md_load_c   = 1'b0;
    assign md_res_c    = '0;
`endif

    // A consume and a new load on the same edge: the new result wins
    always_comb begin
        out_valid_d   = out_valid_q;
        out_res_d     = out_res_q;
        out_flag_d    = out_flag_q;
        out_illegal_d = out_illegal_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (accept_c && !md_accept_c) begin
            out_valid_d   = 1'b1;
            out_res_d     = sc_res_c;
            out_flag_d    = sc_flag_c;
            out_illegal_d = sc_illegal_c;
        end else if (md_load_c) begin
            out_valid_d   = 1'b1;
            out_res_d     = md_res_c;
            out_flag_d    = 1'b0;
            out_illegal_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_res_q     <= '0;
            out_flag_q    <= 1'b0;
            out_illegal_q <= 1'b0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_res_q     <= out_res_d;
            out_flag_q    <= out_flag_d;
            out_illegal_q <= out_illegal_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_res     = out_res_q;
    assign out_flag    = out_flag_q;
    assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_alu_mc.sv
// Randomized self-checking bench for alu_mc against an arithmetic reference model.
// Follows ALU_MC_MULDIV_EN so the expected mul/div behaviour matches the build.
module tb_alu_mc;

    localparam int unsigned XLEN = 32;
    localparam int unsigned SHW  = 5;
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
`ifdef ALU_MC_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      in_op;
    logic [XLEN-1:0] in_srca;
    logic [XLEN-1:0] in_srcb;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_res;
    logic            out_flag;
    logic            out_illegal;
    logic            busy;

    int n_tests = 0;
    int n_fail  = 0;

    alu_mc #(
        .XLEN (XLEN)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_srca     (in_srca),
        .in_srcb     (in_srcb),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_res     (out_res),
        .out_flag    (out_flag),
        .out_illegal (out_illegal),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: res = b OP a, straight from the op table
    function automatic void model(input logic [4:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                  output logic [XLEN-1:0] r, output logic f, output logic ill, output int lat);
        logic [2*XLEN-1:0] p;
        p   = {{XLEN{1'b0}}, b} * {{XLEN{1'b0}}, a};
        r   = '0;
        f   = 1'b0;
        ill = 1'b0;
        lat = 1;
        case (op)
            5'h00: r = b;
            5'h01: r = b + a;
            5'h02: r = b - a;
            5'h03: r = b & a;
            5'h04: r = b | a;
            5'h05: r = b ^ a;
            5'h06: r = b << a[SHW-1:0];
            5'h07: r = b >> a[SHW-1:0];
            5'h08: r = $signed(b) >>> a[SHW-1:0];
            5'h09: f = (b == a);
            5'h0A: f = (b != a);
            5'h0B: f = (b < a);
            5'h0C: f = (b > a);
            5'h0D: f = (b >= a);
            5'h0E: f = ($signed(b) < $signed(a));
            5'h0F: f = ($signed(b) > $signed(a));
            5'h10: f = ($signed(b) >= $signed(a));
            5'h11: r = b << 16;
            5'h12: r = p[XLEN-1:0];
            5'h13: r = p[2*XLEN-1:XLEN];
            5'h14: r = (a == '0) ? '1 : b / a;
            5'h15: r = (a == '0) ? b : b % a;
            5'h16: begin
                if (a == '0)                     r = '1;
                else if (b == MIN && a == '1)    r = MIN;
                else                             r = XLEN'($signed(b) / $signed(a));
            end
            5'h17: begin
                if (a == '0)                     r = b;
                else if (b == MIN && a == '1)    r = '0;
                else                             r = XLEN'($signed(b) % $signed(a));
            end
            default: ill = 1'b1;
        endcase
        if (op >= 5'h09 && op <= 5'h10) r = XLEN'(f);
        if (op >= 5'h12 && op <= 5'h17) begin
            if (MD_EN) begin
                lat = XLEN + 2;
            end else begin
                r   = '0;
                ill = 1'b1;
            end
        end
    endfunction

    function automatic logic [XLEN-1:0] rand_opnd();
        int unsigned sel;
        sel = $urandom_range(0, 7);
        case (sel)
            0:       return '0;
            1:       return '1;
            2:       return MIN;
            3:       return XLEN'($urandom_range(0, 40));
            default: return XLEN'($urandom);
        endcase
    endfunction

    // Issue one op, check latency/busy/result, optionally stall the consumer for hold cycles
    task automatic run_op(input logic [4:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input int hold, output logic [XLEN-1:0] got);
        logic [XLEN-1:0] er;
        logic            ef;
        logic            ei;
        logic            bz_bad;
        int              elat;
        int              lat;
        int              w;
        string           t;
        model(op, a, b, er, ef, ei, elat);
        t = $sformatf("op%02h a=%h b=%h", op, a, b);
        #1;
        w = 0;
        while (!in_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        check({t, " in_ready"}, XLEN'(in_ready), XLEN'(1));
        in_valid = 1'b1;
        in_op    = op;
        in_srca  = a;
        in_srcb  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_op    = 5'($urandom);
        in_srca  = XLEN'($urandom);
        in_srcb  = XLEN'($urandom);
        if (hold > 0) out_ready = 1'b0;
        lat    = 1;
        bz_bad = 1'b0;
        while (!out_valid && lat < 200) begin
            if (busy !== 1'b1) bz_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        check({t, " latency"}, XLEN'(lat), XLEN'(elat));
        if (elat > 1) check({t, " busy_during"}, XLEN'(bz_bad), XLEN'(0));
        check({t, " busy_after"}, XLEN'(busy), XLEN'(0));
        check({t, " res"}, out_res, er);
        check({t, " flag"}, XLEN'(out_flag), XLEN'(ef));
        check({t, " illegal"}, XLEN'(out_illegal), XLEN'(ei));
        got = out_res;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({t, " hold_res"}, out_res, er);
            check({t, " hold_valid"}, XLEN'(out_valid), XLEN'(1));
            check({t, " hold_in_ready"}, XLEN'(in_ready), XLEN'(0));
        end
        out_ready = 1'b1;
    endtask

    initial begin
        logic [XLEN-1:0] g;
        logic            seen;
        logic [4:0]      rop;
        int              rhold;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_srca   = '0;
        in_srcb   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", XLEN'(out_valid), XLEN'(0));
        check("reset out_res", out_res, XLEN'(0));
        check("reset out_flag", XLEN'(out_flag), XLEN'(0));
        check("reset out_illegal", XLEN'(out_illegal), XLEN'(0));
        check("reset busy", XLEN'(busy), XLEN'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(5'h01, 32'd5, 32'd7, 0, g);
        check("plan ADD", g, 32'd12);
        run_op(5'h02, 32'd5, 32'd7, 0, g);
        check("plan SUB", g, 32'd2);
        run_op(5'h0E, 32'd1, 32'hFFFF_FFFF, 0, g);
        check("plan LT res", g, 32'd1);
        check("plan LT flag", XLEN'(out_flag), XLEN'(1));
        run_op(5'h0B, 32'd1, 32'hFFFF_FFFF, 0, g);
        check("plan LTU res", g, 32'd0);
        check("plan LTU flag", XLEN'(out_flag), XLEN'(0));
        run_op(5'h12, 32'h0001_0000, 32'h0003_0000, 0, g);
        check("plan MUL", g, 32'd0);
        run_op(5'h13, 32'h0001_0000, 32'h0003_0000, 0, g);
        check("plan MULHU", g, MD_EN ? 32'd3 : 32'd0);
        run_op(5'h16, 32'hFFFF_FFFF, 32'h8000_0000, 0, g);
        check("plan DIV ovf", g, MD_EN ? 32'h8000_0000 : 32'd0);
        run_op(5'h14, 32'd0, 32'd9, 0, g);
        check("plan DIVU by0", g, MD_EN ? 32'hFFFF_FFFF : 32'd0);
        run_op(5'h17, 32'd3, 32'hFFFF_FFF9, 0, g);
        check("plan REM", g, MD_EN ? 32'hFFFF_FFFF : 32'd0);
        run_op(5'h07, 32'd33, 32'h80, 5, g);
        check("plan SRL", g, 32'h40);
        run_op(5'h1F, 32'h1234, 32'h5678, 0, g);
        check("plan 1F res", g, 32'd0);
        check("plan 1F illegal", XLEN'(out_illegal), XLEN'(1));
        run_op(5'h11, 32'd0, 32'h1234, 0, g);
        check("plan LUI", g, 32'h1234_0000);
        run_op(5'h08, 32'd4, MIN, 0, g);
        check("plan SRA", g, 32'hF800_0000);

        // Reset while a DIV is outstanding: nothing may come out afterwards
        #1;
        in_valid = 1'b1;
        in_op    = 5'h16;
        in_srca  = 32'd3;
        in_srcb  = 32'd100;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst out_valid", XLEN'(out_valid), XLEN'(0));
        check("midrst busy", XLEN'(busy), XLEN'(0));
        check("midrst out_res", out_res, XLEN'(0));
        check("midrst in_ready", XLEN'(in_ready), XLEN'(1));
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < XLEN + 6; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("midrst no_result", XLEN'(seen), XLEN'(0));
        out_ready = 1'b1;

        for (int i = 0; i < 300; i++) begin
            rop   = 5'($urandom_range(0, 31));
            rhold = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
            run_op(rop, rand_opnd(), rand_opnd(), rhold, g);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the core's combinational ALU.
- Keeps the existing 5-bit op encoding and the operand order `res = srcb OP srca`.
- Adds registered output, a valid/ready handshake on both sides, and iterative multiply/divide/remainder.
- Sits between decode/issue and writeback in the core datapath; stalls issue via `in_ready` while a long op runs.

Parameters:
- XLEN, 32, datapath width in bits; must be ≥ 8 and a power of two.
- SHW, $clog2(XLEN), shift-amount width; shifts use `srca[SHW-1:0]` only.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  request present
- in_ready  out  1  request accepted when `in_valid & in_ready` at a rising edge
- in_op  in  5  operation code
- in_srca  in  XLEN  operand A
- in_srcb  in  XLEN  operand B
- out_valid  out  1  result register holds an unconsumed result
- out_ready  in  1  consumer takes the result when `out_valid & out_ready`
- out_res  out  XLEN  result
- out_flag  out  1  compare outcome; 0 for non-compare ops
- out_illegal  out  1  op not supported
- busy  out  1  multi-cycle op in progress

Behaviour:
- Ops 0x00–0x10 keep their existing meanings: PASS, ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, EQ, NE, LTU, GTU, GEU, LT, GT, GE.
- Compare ops (EQ through GE) set `res = {0…, flag}`.
- 0x11 LUI: `res = srcb << 16`, flag = 0.
- New ops:
  - 0x12 MUL: low XLEN bits of the product.
  - 0x13 MULHU: high XLEN bits of the unsigned product.
  - 0x14 DIVU: `srcb / srca`.
  - 0x15 REMU: `srcb % srca`.
  - 0x16 DIV: signed `srcb / srca`.
  - 0x17 REM: signed `srcb % srca`.
- Codes 0x18–0x1F: `res = 0`, flag = 0, illegal = 1, single-cycle.
- FSM states:
  - IDLE → CALC: on accepting a mul/div op.
  - CALC: one shift-add or restoring-subtract step per cycle; iteration counter runs XLEN → 0.
  - CALC → FIN: after the last step.
  - FIN: applies sign fix-up and loads the output register; → IDLE.
- `in_ready = (state == IDLE) & (!out_valid | out_ready)`. Back-to-back single-cycle ops therefore run at 1 per cycle.
- Latency from the acceptance edge:
  - Single-cycle ops: out_valid high after 1 edge.
  - Mul/div ops: out_valid high after XLEN+2 edges.
- Operands and op are captured at acceptance; input changes afterwards are ignored.
- Output register is held stable while `out_valid & !out_ready`.
- Divide by zero: quotient = all ones, remainder = srcb.
- Signed overflow (DIV MIN / −1): quotient = MIN, remainder = 0.
- Signed div/rem work on magnitudes:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of srcb.
- `busy = (state != IDLE)`.
- Reset values: state = IDLE, out_valid = 0, out_res = 0, out_flag = 0, out_illegal = 0, busy = 0.
- Reset mid-operation abandons the op; no result is produced.
- Simultaneous output consume and new accept in one cycle is legal; the new result replaces the old one on that edge.

Optional Feature:
- Macro: `ALU_MC_MULDIV_EN`.
- Defined: ops 0x12–0x17 behave as above.
- Undefined:
  - Ops 0x12–0x17 are illegal (`res = 0`, illegal = 1), single-cycle.
  - No CALC/FIN datapath is synthesised; busy is tied to 0.

Decomposition:
- Package `alu_pkg`:
  - `alu_op_e` enum covering all 32 codes.
  - `alu_state_e` enum (IDLE, CALC, FIN).
  - Helper functions `is_cmp(op)` and `is_muldiv(op)`.
- Sub-module `alu_muldiv_iter`: iterative multiply/divide engine with start/done, instantiated under the macro.
- Single-cycle ops stay in the top-level combinational block.

Test Plan:
- ADD, srca = 5, srcb = 7 → 1 cycle later out_res = 12, flag = 0, illegal = 0; sending SUB on the next cycle with the same operands → out_res = 2 one cycle later.
- LT, srca = 1, srcb = 0xFFFFFFFF → res = 1, flag = 1; then LTU with the same operands → res = 0, flag = 0.
- MUL, srca = 0x10000, srcb = 0x30000 → out_valid at edge 34 (XLEN = 32), out_res = 0, busy high throughout; then MULHU with the same operands → res = 3.
- DIV, srca = 0xFFFFFFFF, srcb = 0x80000000 → res = 0x80000000; DIVU, srca = 0, srcb = 9 → 0xFFFFFFFF; REM, srca = 3, srcb = −7 → res = −1.
- SRL, srca = 33, srcb = 0x80 → res = 0x40 (shift amount masked to 1); holding out_ready = 0 for 5 cycles keeps out_res stable and in_ready low.
- Op 0x1F → illegal = 1, res = 0; asserting rst_n = 0 mid-DIV → next cycle state = IDLE, out_valid = 0, no result produced.
